goertzel_gain_ch: RTL and testbench

Parametrised, multi-channel, pipelined gain stage for the Goertzel datapath, replacing the fixed single-channel registered negation block. Each sample carries a channel tag and a mode. The block applies bypass, negate, coefficient multiply or negated coefficient multiply, then rounds and saturates to the data width. It sits between the resonator adders and the feedback/output registers and uses a valid/ready stream with backpressure.

---
 rtl/goertzel_pkg.sv | 48 ++++
 rtl/goertzel_gain_ch_if.sv | 28 ++
 rtl/goertzel_coef_rf.sv | 40 ++++
 rtl/goertzel_gain_ch.sv | 117 +++++++++++
 tb/tb_goertzel_gain_ch.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel gain stage: mode encodings, the
// round/saturate helper and the unity-coefficient constant.
package goertzel_pkg;

  typedef enum logic [1:0] {
    MODE_BYP   = 2'b00,
    MODE_NEG   = 2'b01,
    MODE_COEF  = 2'b10,
    MODE_NCOEF = 2'b11
  } mode_t;

  // Working width of the round/saturate helper; any product up to this wide fits.
  localparam int RS_W = 128;

  typedef struct packed {
    logic                   sat;
    logic signed [RS_W-1:0] y;
  } rs_t;

  // Round half up by dropping frac bits, then clip to an nw-bit signed range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] p,
                                    input int frac, input int nw);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    one = RS_W'(1);
    r   = (p + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (nw - 1)) - one;
    lo  = -(one <<< (nw - 1));
    res.sat = 1'b0;
    res.y   = r;
    if (r > hi) begin
      res.y   = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.y   = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [RS_W-1:0] unity_coef(input int frac);
    return RS_W'(1) << frac;
  endfunction

endpackage

// File: rtl/goertzel_gain_ch_if.sv
// Sample stream into and out of the gain stage, with valid/ready on each side.
interface goertzel_gain_ch_if
  import goertzel_pkg::*;
#(
  parameter int N   = 32,
  parameter int CHW = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [CHW-1:0] in_ch;
  mode_t          in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic [CHW-1:0] out_ch;
  logic           out_sat;

  modport master (
    output in_valid, in_data, in_ch, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_ch, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_sat
  );
endinterface

// File: rtl/goertzel_coef_rf.sv
// Per-channel coefficient register file: one write port, one combinational
// read port, every entry resets to unity.
module goertzel_coef_rf
  import goertzel_pkg::*;
#(
  parameter int CW   = 18,
  parameter int FRAC = 16,
  parameter int CH   = 4,
  parameter int CHW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CHW-1:0]        wr_addr,
  input  logic signed [CW-1:0]  wr_data,
  input  logic [CHW-1:0]        rd_addr,
  output logic signed [CW-1:0]  rd_data
);
  localparam logic signed [CW-1:0] UNITY = CW'(unity_coef(FRAC));

  logic signed [CW-1:0] coef_arr [CH];

  for (genvar gi = 0; gi < CH; gi++) begin : g_ent
    logic signed [CW-1:0] coef_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        coef_reg <= UNITY;
      end else if (we && (int'(wr_addr) == gi)) begin
        coef_reg <= wr_data;
      end
    end

    assign coef_arr[gi] = coef_reg;
  end

  // Tags beyond the last channel fall back to entry 0.
  assign rd_data = (int'(rd_addr) < CH) ? coef_arr[rd_addr] : coef_arr[0];

endmodule

// File: rtl/goertzel_gain_ch.sv
// Two-stage multi-channel gain: S1 captures sample and coefficient, S2
// multiplies/negates, rounds, saturates and holds the result for downstream.
module goertzel_gain_ch
  import goertzel_pkg::*;
#(
  parameter int N    = 32,
  parameter int CW   = 18,
  parameter int FRAC = 16,
  parameter int CH   = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  goertzel_gain_ch_if.slave    bus,
  input  logic                 coef_we,
  input  logic [CHW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_data
);
  localparam int PW = N + CW + 1;

  logic                 s1_valid_reg;
  logic signed [N-1:0]  s1_x_reg;
  logic [CHW-1:0]       s1_ch_reg;
  mode_t                s1_mode_reg;
  logic signed [CW-1:0] s1_coef_reg;

  logic                 out_valid_reg;
  logic [N-1:0]         out_data_reg;
  logic [CHW-1:0]       out_ch_reg;
  logic                 out_sat_reg;

  logic                 s1_adv;
  logic                 s2_adv;
  logic signed [CW-1:0] rd_coef;
  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] ce;
  logic signed [PW-1:0] p;
  rs_t                  rs;
  logic                 unused_rs_hi;

  goertzel_coef_rf #(
    .CW   (CW),
    .FRAC (FRAC),
    .CH   (CH),
    .CHW  (CHW)
  ) u_coef_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (coef_we),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_addr (bus.in_ch),
    .rd_data (rd_coef)
  );

  assign s2_adv       = ~out_valid_reg | bus.out_ready;
  assign s1_adv       = ~s1_valid_reg | s2_adv;
  assign bus.in_ready = s1_adv;

  // The read port sees the register contents before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_ch_reg    <= '0;
      s1_mode_reg  <= MODE_BYP;
      s1_coef_reg  <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x_reg    <= bus.in_data;
        s1_ch_reg   <= bus.in_ch;
        s1_mode_reg <= bus.in_mode;
        s1_coef_reg <= rd_coef;
      end
    end
  end

  // Bypass/negate scale x by 2^FRAC so every mode shares the same rounding path.
  always_comb begin
    xe = PW'(s1_x_reg);
    ce = PW'(s1_coef_reg);
    if (s1_mode_reg[1]) begin
      p = xe * ce;
    end else begin
      p = xe <<< FRAC;
    end
    if (s1_mode_reg[0]) begin
      p = -p;
    end
    rs = round_sat(RS_W'(p), FRAC, N);
  end

  assign unused_rs_hi = ^rs.y[RS_W-1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_sat_reg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= rs.y[N-1:0];
        out_ch_reg   <= s1_ch_reg;
        out_sat_reg  <= rs.sat;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_sat   = out_sat_reg;

endmodule

// File: tb/tb_goertzel_gain_ch.sv
// Directed bench for goertzel_gain_ch: hand-computed vectors, stall stream,
// same-edge coefficient write and mid-flight reset.
module tb_goertzel_gain_ch;
  import goertzel_pkg::*;

  logic        clk;
  logic        rst;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [17:0] coef_data;

  int n_assert = 0;
  int n_fail   = 0;

  goertzel_gain_ch_if #(.N(32), .CHW(2)) bus ();

  goertzel_gain_ch #(.N(32), .CW(18), .FRAC(16), .CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [31:0] x, input logic [1:0] ch, input mode_t mode);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_ch    = ch;
    bus.in_mode  = mode;
    k = 0;
    #1;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] y, input logic [1:0] ch, input logic sat);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_y"}, bus.out_data, y);
    check({tag, "_ch"}, 32'(bus.out_ch), 32'(ch));
    check({tag, "_sat"}, 32'(bus.out_sat), 32'(sat));
    $display("txn %s: y=0x%08h ch=%0d sat=%0b", tag, bus.out_data, bus.out_ch, bus.out_sat);
  endtask

  task automatic run1(input string tag, input logic [31:0] x, input logic [1:0] ch, input mode_t mode,
                      input logic [31:0] y, input logic sat);
    send(x, ch, mode);
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    expect_out(tag, y, ch, sat);
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic [17:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  logic [31:0] exp_y_q [$];
  logic [1:0]  exp_ch_q [$];

  initial begin
    int sent;
    int got;
    int cyc;
    logic [31:0] xs;

    rst           = 1'b1;
    coef_we       = 1'b0;
    coef_addr     = '0;
    coef_data     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ch     = '0;
    bus.in_mode   = MODE_BYP;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    run1("unity77", 32'd77, 2'd0, MODE_COEF, 32'd77, 1'b0);

    write_coef(2'd0, 18'h08000);
    run1("half1000", 32'd1000, 2'd0, MODE_COEF, 32'd500, 1'b0);
    run1("half3", 32'd3, 2'd0, MODE_COEF, 32'd2, 1'b0);
    run1("half_m3", -32'sd3, 2'd0, MODE_COEF, -32'sd1, 1'b0);

    run1("neg_min", 32'h8000_0000, 2'd0, MODE_NEG, 32'h7FFF_FFFF, 1'b1);
    run1("byp_min", 32'h8000_0000, 2'd0, MODE_BYP, 32'h8000_0000, 1'b0);

    // 0x1FFFF is 131071/65536: 2^30 lands just below full scale, a larger x clips.
    write_coef(2'd1, 18'h1FFFF);
    run1("c2_pos", 32'h4000_0000, 2'd1, MODE_COEF, 32'd2147467264, 1'b0);
    run1("c2_pos_sat", 32'h4010_0000, 2'd1, MODE_COEF, 32'h7FFF_FFFF, 1'b1);
    run1("c2_neg", 32'h4000_0000, 2'd1, MODE_NCOEF, -32'sd2147467264, 1'b0);
    run1("c2_neg_sat", 32'h4010_0000, 2'd1, MODE_NCOEF, 32'h8000_0000, 1'b1);

    // Stream of 8 with a 5-cycle downstream stall; odd samples are negated.
    @(negedge clk);
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 8) begin
        xs           = 32'(sent * 1000 - 3000);
        bus.in_valid = 1'b1;
        bus.in_data  = xs;
        bus.in_ch    = 2'(sent % 4);
        bus.in_mode  = (sent % 2 == 1) ? MODE_NEG : MODE_BYP;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (!bus.out_ready) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        if (got < exp_y_q.size()) check("stall_hold_y", bus.out_data, exp_y_q[got]);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < exp_y_q.size()) begin
          check("stream_y", bus.out_data, exp_y_q[got]);
          check("stream_ch", 32'(bus.out_ch), 32'(exp_ch_q[got]));
        end
        $display("txn stream[%0d]: y=0x%08h ch=%0d", got, bus.out_data, bus.out_ch);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_y_q.push_back((sent % 2 == 1) ? 32'(-(sent * 1000 - 3000)) : 32'(sent * 1000 - 3000));
        exp_ch_q.push_back(2'(sent % 4));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd8);
    @(negedge clk);

    // Coefficient write on the same edge as a ch-2 capture.
    coef_we   = 1'b1;
    coef_addr = 2'd2;
    coef_data = 18'h04000;
    send(32'd400, 2'd2, MODE_COEF);
    coef_we   = 1'b0;
    check("wr_same_lat1", 32'(bus.out_valid), 32'd0);
    expect_out("wr_same_old", 32'd400, 2'd2, 1'b0);
    run1("wr_same_new", 32'd400, 2'd2, MODE_COEF, 32'd100, 1'b0);

    // Two samples in flight, then reset.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'd10, 2'd0, MODE_BYP);
    send(32'd20, 2'd1, MODE_BYP);
    #1;
    check("flight_valid", 32'(bus.out_valid), 32'd1);
    check("flight_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rstmid_no_stale", 32'(bus.out_valid), 32'd0);
    run1("rstmid_unity", 32'd77, 2'd0, MODE_COEF, 32'd77, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
